ahb_dmem_slave: RTL and testbench
=================================

Name: ahb_dmem_slave

Overview:
- AHB-lite responder that terminates the core's data-memory bus: address, htrans, write request, write mask and write data in; hrdata, hready and hresp out.
- Holds a word-organised, byte-maskable SRAM model with a configurable number of wait states.
- Returns a two-cycle ERROR response for out-of-range addresses.
- Used in the core testbench and SoC as the data slave, and as the reference for any future bus-slave work.

Parameters:
- BASE_ADDR, 32'h0001_0000, byte address of word 0; must be aligned to 4*DEPTH.
- DEPTH, 1024, number of 32-bit words; power of 2, range 16..65536.
- WAIT_STATES, 0, number of hready-low cycles inserted per OKAY data phase; range 0..7.

Ports:
- clk_in, input, 1, clock; all state changes on the rising edge.
- rst_in, input, 1, asynchronous active-low reset.
- haddr_in, input, 32, address-phase byte address; bits [1:0] are ignored and byte lanes come from hwmask_in.
- htrans_in, input, 2, address-phase transfer type. 2'b10 NONSEQ and 2'b11 SEQ are active. 2'b00 IDLE and 2'b01 BUSY are inactive.
- hwrite_in, input, 1, address phase; 1 = write.
- hwmask_in, input, 4, address-phase byte-lane write mask; bit i enables byte lane i, [8i+7:8i].
- hwdata_in, input, 32, data-phase write data.
- hrdata_out, output, 32, read data; valid in the last data-phase cycle of an OKAY read.
- hready_out, output, 1, 1 = transfer complete / slave ready to accept an address phase.
- hresp_out, output, 1, 0 = OKAY, 1 = ERROR.

Behaviour:
- Reset (rst_in=0, asynchronous): state=IDLE, hready_out=1, hresp_out=0, hrdata_out=0, wait counter=0, pending write discarded. SRAM contents are not reset. A transfer in flight when reset asserts is abandoned: no write occurs and no response is given.
- Acceptance: an address phase is accepted on a rising edge where hready_out=1 and htrans_in[1]=1. Captured values: word index, (haddr_in-BASE_ADDR)>>2; hwrite_in; hwmask_in; in_range flag.
- in_range = BASE_ADDR <= haddr_in < BASE_ADDR+4*DEPTH, computed as an unsigned 32-bit comparison.
- Inactive htrans (IDLE or BUSY) with hready_out=1: no state change, hresp_out=0, next-cycle hready_out=1.
- State machine, states IDLE, WAIT, DATA, ERR1, ERR2:
  - IDLE: no data phase pending. On an accepted in-range transfer, go to WAIT if WAIT_STATES>0, otherwise to DATA. On an accepted out-of-range transfer, go to ERR1.
  - WAIT: hready_out=0, hresp_out=0. The counter loads WAIT_STATES on acceptance and decrements each cycle. Move to DATA when the counter reaches 1.
  - DATA: hready_out=1, hresp_out=0, for exactly 1 cycle. A new address phase may be accepted in the same cycle, giving back-to-back pipelining. Next state is chosen from the new transfer as in IDLE, else IDLE.
  - ERR1: hready_out=0, hresp_out=1, for 1 cycle; go to ERR2.
  - ERR2: hready_out=1, hresp_out=1, for 1 cycle. An address phase presented here is accepted normally, because the core never cancels transfers.
- OKAY data phase timing: WAIT_STATES+1 cycles, with hready_out low for the first WAIT_STATES cycles.
- Write:
  - hwdata_in is sampled on the rising edge that ends DATA.
  - Only byte lanes with hwmask_in=1 are updated.
  - An all-zero mask is a legal no-op that still returns OKAY.
  - An ERROR transfer never writes.
- Read:
  - hrdata_out is registered and holds the addressed word during DATA.
  - Read-after-write to the same word in back-to-back transfers must return the newly written bytes. Forward the pending write's masked bytes, merged with the SRAM word.
  - hrdata_out holds its previous value during WAIT, ERR1, ERR2, write phases and idle cycles.
- Word index width is log2(DEPTH); address bits above the range are covered by in_range.

Test Plan:
- Reset: hold rst_in=0 mid-WAIT with WAIT_STATES=3 and a write pending to 0x0001_0010 -> hready_out=1, hresp_out=0, hrdata_out=0 immediately. A later read of 0x0001_0010 shows the old contents.
- WAIT_STATES=0, back-to-back write then read: write 0xDEAD_BEEF mask 4'hF to 0x0001_0004, immediately followed by a read of 0x0001_0004 -> hready_out stays 1 throughout, and hrdata_out=0xDEAD_BEEF in the read data phase via forwarding.
- Byte mask: preload 0x1122_3344 at 0x0001_0008, write 0xAABB_CCDD with mask 4'b0101 -> a readback returns 0x11BB_33DD.
- WAIT_STATES=2, read of 0x0001_0000 -> hready_out is 0 for exactly 2 cycles after acceptance, then 1 with valid hrdata_out and hresp_out=0. Total data phase is 3 cycles.
- Out-of-range: write to 0x0000_FFFC and to BASE_ADDR+4*DEPTH -> each gives hready_out=0/hresp_out=1, then hready_out=1/hresp_out=1. SRAM is unchanged and IDLE is reached after that, with hresp_out=0.
- Error followed by valid: an out-of-range read with an in-range read presented during ERR2 -> the second transfer is accepted and returns OKAY with the correct data.

Source files
------------

// File: rtl/ahb_dmem_slave.sv
// AHB-lite data-memory responder: word-organised, byte-maskable SRAM model
// with configurable wait states, a two-cycle ERROR response for out-of-range
// addresses, and write-to-read forwarding for back-to-back transfers.
module ahb_dmem_slave #(
    parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
    parameter int          DEPTH       = 1024,
    parameter int          WAIT_STATES = 0
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] haddr_in,
    input  logic [1:0]  htrans_in,
    input  logic        hwrite_in,
    input  logic [3:0]  hwmask_in,
    input  logic [31:0] hwdata_in,
    output logic [31:0] hrdata_out,
    output logic        hready_out,
    output logic        hresp_out
);

    localparam int IW = $clog2(DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

    state_t        r_state, w_next;
    logic [31:0]   r_mem [DEPTH];
    logic [IW-1:0] r_idx;
    logic          r_write;
    logic [3:0]    r_mask;
    logic [2:0]    r_cnt;
    logic [31:0]   r_rdata;

    logic          w_accept;
    logic          w_in_range;
    logic [32:0]   w_limit;
    logic [IW-1:0] w_idx;
    logic          w_commit;
    logic [IW-1:0] w_rd_idx;
    logic          w_rd_write;
    logic [31:0]   w_rd_word;
    logic          w_unused;

    // BUSY vs IDLE is irrelevant here; only htrans[1] marks an active transfer
    assign w_unused   = htrans_in[0];

    assign hready_out = !(r_state == S_WAIT || r_state == S_ERR1);
    assign hresp_out  = (r_state == S_ERR1) || (r_state == S_ERR2);
    assign hrdata_out = r_rdata;

    assign w_accept   = hready_out && htrans_in[1];
    // 33-bit upper bound so a base near the top of the map cannot wrap
    assign w_limit    = {1'b0, BASE_ADDR} + 33'(4 * DEPTH);
    assign w_in_range = (haddr_in >= BASE_ADDR) && ({1'b0, haddr_in} < w_limit);
    assign w_idx      = IW'((haddr_in - BASE_ADDR) >> 2);

    // The pending write lands in SRAM on the edge that ends its DATA cycle
    assign w_commit   = (r_state == S_DATA) && r_write;

    // A read enters DATA either straight from acceptance (no wait states)
    // or from WAIT, where the captured address is the one to use
    assign w_rd_idx   = (r_state == S_WAIT) ? r_idx   : w_idx;
    assign w_rd_write = (r_state == S_WAIT) ? r_write : hwrite_in;

    // SRAM word merged with the bytes of a write committing on this same edge
    always_comb begin
        w_rd_word = r_mem[w_rd_idx];
        for (int b = 0; b < 4; b++) begin
            if (w_commit && r_idx == w_rd_idx && r_mask[b])
                w_rd_word[8*b +: 8] = hwdata_in[8*b +: 8];
        end
    end

    // Next-state selection
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DATA, S_ERR2: begin
                w_next = S_IDLE;
                if (w_accept) begin
                    if (!w_in_range)          w_next = S_ERR1;
                    else if (WAIT_STATES > 0) w_next = S_WAIT;
                    else                      w_next = S_DATA;
                end
            end
            S_WAIT:  if (r_cnt == 3'd1) w_next = S_DATA;
            S_ERR1:  w_next = S_ERR2;
            default: w_next = S_IDLE;
        endcase
    end

    // State register and address-phase capture
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_write <= 1'b0;
            r_mask  <= 4'h0;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_idx   <= w_idx;
                r_write <= hwrite_in;
                r_mask  <= hwmask_in;
                r_cnt   <= 3'(WAIT_STATES);
            end else if (r_state == S_WAIT) begin
                r_cnt   <= r_cnt - 3'd1;
            end
        end
    end

    // Read data is loaded on the edge entering DATA and held otherwise
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in)
            r_rdata <= 32'h0;
        else if (w_next == S_DATA && !w_rd_write)
            r_rdata <= w_rd_word;
    end

    // SRAM array: byte-lane masked writes, contents survive reset
    always_ff @(posedge clk_in) begin
        if (w_commit) begin
            for (int b = 0; b < 4; b++) begin
                if (r_mask[b]) r_mem[r_idx][8*b +: 8] <= hwdata_in[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_ahb_dmem_slave.sv
// Directed bench for ahb_dmem_slave: three instances with 0, 2 and 3 wait
// states, a vector table of single transfers plus hand-built pipelined,
// error-recovery, wait-state and reset sequences.
module tb_ahb_dmem_slave;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] haddr  [3];
    logic [1:0]  htrans [3];
    logic        hwrite [3];
    logic [3:0]  hwmask [3];
    logic [31:0] hwdata [3];
    logic [31:0] hrdata [3];
    logic        hready [3];
    logic        hresp  [3];

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int WS = (g == 0) ? 0 : (g == 1) ? 2 : 3;
        ahb_dmem_slave #(.BASE_ADDR(32'h0001_0000), .DEPTH(1024), .WAIT_STATES(WS)) u_dut (
            .clk_in     (clk),
            .rst_in     (rst_n),
            .haddr_in   (haddr[g]),
            .htrans_in  (htrans[g]),
            .hwrite_in  (hwrite[g]),
            .hwmask_in  (hwmask[g]),
            .hwdata_in  (hwdata[g]),
            .hrdata_out (hrdata[g]),
            .hready_out (hready[g]),
            .hresp_out  (hresp[g])
        );
    end

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  mask;
        logic [31:0] data;
        logic [31:0] exp_rd;
        logic        exp_resp;
        int          exp_cyc;
    } vec_t;

    vec_t tbl [15];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One isolated transfer; called and returns at posedge+1 with the slave idle
    task automatic xfer(input int d, input logic wr, input logic [31:0] addr,
                        input logic [3:0] mask, input logic [31:0] wd,
                        output logic [31:0] rd, output logic resp, output int cyc);
        haddr[d] = addr; htrans[d] = 2'b10; hwrite[d] = wr; hwmask[d] = mask;
        @(posedge clk); #1;
        htrans[d] = 2'b00; hwdata[d] = wd;
        cyc = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            cyc++;
            if (hready[d]) break;
        end
        rd = hrdata[d]; resp = hresp[d];
        @(posedge clk); #1;
    endtask

    // Write immediately followed by a read of the same word on instance 0
    task automatic b2b(input logic [31:0] addr, input logic [3:0] mask,
                       input logic [31:0] wd, input logic [31:0] exp);
        haddr[0] = addr; htrans[0] = 2'b10; hwrite[0] = 1'b1; hwmask[0] = mask;
        @(posedge clk); #1;
        hwrite[0] = 1'b0; hwdata[0] = wd;
        @(negedge clk);
        chk("b2b_wr_hready", 32'(hready[0]), 32'd1);
        @(posedge clk); #1;
        htrans[0] = 2'b00;
        @(negedge clk);
        chk("b2b_rd_hready", 32'(hready[0]), 32'd1);
        chk("b2b_rd_hresp", 32'(hresp[0]), 32'd0);
        chk("b2b_rd_fwd", hrdata[0], exp);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic        resp;
        int          cyc;

        //          wr    addr          mask   data          exp_rd        resp cyc
        tbl[0]  = '{1'b1, 32'h0001_0000, 4'hF, 32'h0102_0304, 32'h0,        1'b0, 1};
        tbl[1]  = '{1'b1, 32'h0001_0FFC, 4'hF, 32'h0BAD_CAFE, 32'h0,        1'b0, 1};
        tbl[2]  = '{1'b1, 32'h0001_0008, 4'hF, 32'h1122_3344, 32'h0,        1'b0, 1};
        tbl[3]  = '{1'b1, 32'h0001_0008, 4'h5, 32'hAABB_CCDD, 32'h0,        1'b0, 1};
        tbl[4]  = '{1'b0, 32'h0001_0008, 4'h0, 32'h0,         32'h11BB_33DD, 1'b0, 1};
        tbl[5]  = '{1'b1, 32'h0001_0020, 4'hF, 32'hCAFE_F00D, 32'h0,        1'b0, 1};
        tbl[6]  = '{1'b1, 32'h0001_0020, 4'h0, 32'h0000_0000, 32'h0,        1'b0, 1};
        tbl[7]  = '{1'b0, 32'h0001_0020, 4'h0, 32'h0,         32'hCAFE_F00D, 1'b0, 1};
        tbl[8]  = '{1'b1, 32'h0000_FFFC, 4'hF, 32'hFFFF_FFFF, 32'h0,        1'b1, 2};
        tbl[9]  = '{1'b1, 32'h0001_1000, 4'hF, 32'hFFFF_FFFF, 32'h0,        1'b1, 2};
        tbl[10] = '{1'b0, 32'h0000_FFFC, 4'h0, 32'h0,         32'h0,        1'b1, 2};
        tbl[11] = '{1'b0, 32'h0001_0FFC, 4'h0, 32'h0,         32'h0BAD_CAFE, 1'b0, 1};
        tbl[12] = '{1'b0, 32'h0001_0000, 4'h0, 32'h0,         32'h0102_0304, 1'b0, 1};
        tbl[13] = '{1'b1, 32'h0001_0000, 4'h8, 32'hEE00_0000, 32'h0,        1'b0, 1};
        tbl[14] = '{1'b0, 32'h0001_0000, 4'h0, 32'h0,         32'hEE02_0304, 1'b0, 1};

        for (int d = 0; d < 3; d++) begin
            haddr[d] = 32'h0; htrans[d] = 2'b00; hwrite[d] = 1'b0;
            hwmask[d] = 4'h0; hwdata[d] = 32'h0;
        end

        // Reset state
        repeat (3) @(posedge clk);
        for (int d = 0; d < 3; d++) begin
            chk("rst_hready", 32'(hready[d]), 32'd1);
            chk("rst_hresp", 32'(hresp[d]), 32'd0);
            chk("rst_hrdata", hrdata[d], 32'h0);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Vector table, isolated transfers on the zero-wait instance
        for (int i = 0; i < 15; i++) begin
            xfer(0, tbl[i].wr, tbl[i].addr, tbl[i].mask, tbl[i].data, rd, resp, cyc);
            chk($sformatf("vec%0d_hresp", i), 32'(resp), 32'(tbl[i].exp_resp));
            chk($sformatf("vec%0d_cycles", i), 32'(cyc), 32'(tbl[i].exp_cyc));
            if (!tbl[i].wr && !tbl[i].exp_resp)
                chk($sformatf("vec%0d_hrdata", i), rd, tbl[i].exp_rd);
            @(negedge clk);
            chk($sformatf("vec%0d_idle_hready", i), 32'(hready[0]), 32'd1);
            chk($sformatf("vec%0d_idle_hresp", i), 32'(hresp[0]), 32'd0);
            @(posedge clk); #1;
        end

        // Back-to-back write/read with forwarding (full and partial mask)
        b2b(32'h0001_0004, 4'hF, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        b2b(32'h0001_0008, 4'h2, 32'h0000_9900, 32'h11BB_99DD);

        // Out-of-range read with an in-range read presented during ERR2
        haddr[0] = 32'h0002_0000; htrans[0] = 2'b10; hwrite[0] = 1'b0;
        @(posedge clk); #1;
        htrans[0] = 2'b00;
        @(negedge clk);
        chk("err1_hready", 32'(hready[0]), 32'd0);
        chk("err1_hresp", 32'(hresp[0]), 32'd1);
        @(posedge clk); #1;
        haddr[0] = 32'h0001_0000; htrans[0] = 2'b11;
        @(negedge clk);
        chk("err2_hready", 32'(hready[0]), 32'd1);
        chk("err2_hresp", 32'(hresp[0]), 32'd1);
        @(posedge clk); #1;
        htrans[0] = 2'b00;
        @(negedge clk);
        chk("after_err_hready", 32'(hready[0]), 32'd1);
        chk("after_err_hresp", 32'(hresp[0]), 32'd0);
        chk("after_err_hrdata", hrdata[0], 32'hEE02_0304);
        @(posedge clk); #1;

        // Two wait states: hready low for exactly two cycles, then data
        xfer(1, 1'b1, 32'h0001_0000, 4'hF, 32'h7766_5544, rd, resp, cyc);
        chk("ws2_wr_cycles", 32'(cyc), 32'd3);
        haddr[1] = 32'h0001_0000; htrans[1] = 2'b10; hwrite[1] = 1'b0;
        @(posedge clk); #1;
        htrans[1] = 2'b00;
        @(negedge clk); chk("ws2_c1_hready", 32'(hready[1]), 32'd0);
        @(negedge clk); chk("ws2_c2_hready", 32'(hready[1]), 32'd0);
        @(negedge clk);
        chk("ws2_c3_hready", 32'(hready[1]), 32'd1);
        chk("ws2_c3_hresp", 32'(hresp[1]), 32'd0);
        chk("ws2_c3_hrdata", hrdata[1], 32'h7766_5544);
        @(posedge clk); #1;

        // Reset in the middle of a wait-stated write abandons it
        xfer(2, 1'b1, 32'h0001_0010, 4'hF, 32'h5555_AAAA, rd, resp, cyc);
        xfer(2, 1'b0, 32'h0001_0010, 4'h0, 32'h0, rd, resp, cyc);
        chk("ws3_rd_cycles", 32'(cyc), 32'd4);
        chk("ws3_rd_hrdata", rd, 32'h5555_AAAA);
        haddr[2] = 32'h0001_0010; htrans[2] = 2'b10; hwrite[2] = 1'b1; hwmask[2] = 4'hF;
        @(posedge clk); #1;
        htrans[2] = 2'b00; hwdata[2] = 32'h1234_5678;
        @(negedge clk);
        chk("ws3_wait_hready", 32'(hready[2]), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_hready", 32'(hready[2]), 32'd1);
        chk("midrst_hresp", 32'(hresp[2]), 32'd0);
        chk("midrst_hrdata", hrdata[2], 32'h0);
        @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        xfer(2, 1'b0, 32'h0001_0010, 4'h0, 32'h0, rd, resp, cyc);
        chk("postrst_hrdata", rd, 32'h5555_AAAA);
        chk("postrst_hresp", 32'(resp), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
